// File: rtl/pkt_rx_reader.sv
// pkt_rx_reader: pulls frames from a MAC rx port into a small output FIFO,
// reporting per-frame length/error status and running statistics.
module pkt_rx_reader #(
  parameter int FIFO_DEPTH = 8,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk_156m25,
  input  logic        reset_156m25,
  input  logic        pkt_rx_avail,
  output logic        pkt_rx_ren,
  input  logic        pkt_rx_val,
  input  logic [63:0] pkt_rx_data,
  input  logic        pkt_rx_sop,
  input  logic        pkt_rx_eop,
  input  logic        pkt_rx_err,
  input  logic [2:0]  pkt_rx_mod,
  output logic [63:0] out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_err,
  output logic [2:0]  out_mod,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_done,
  output logic [13:0] frame_len,
  output logic        frame_bad,
  output logic [31:0] frame_count,
  output logic [15:0] err_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, READ} state_t;
  state_t state, state_nx;
  logic [69:0] mem [FIFO_DEPTH];
  logic [69:0] head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [AW+1:0] need;
  logic ren_q, in_frame, err_acc, pend_v, pend_bad;
  logic [13:0] len, len_nx, pend_len, bytes;
  logic [14:0] sum;
  logic [16:0] err_sum;
  logic err_nx, bad_nx, discard, trunc, close, push, pop, we;
  always_comb begin
    state_nx = state;
    pkt_rx_ren = 1'b0;
    need = {1'b0, count} + (AW+2)'(ren_q);
    if (state == IDLE) begin
      state_nx = pkt_rx_avail ? READ : IDLE;
    end else begin
      state_nx = (pkt_rx_val && pkt_rx_eop) ? IDLE : READ;
      pkt_rx_ren = !(pkt_rx_val && pkt_rx_eop) && need <= (AW+2)'(FIFO_DEPTH - 2);
    end
  end
  assign bytes = (pkt_rx_eop && pkt_rx_mod != 3'd0) ? {11'd0, pkt_rx_mod} : 14'd8;
  assign sum = (pkt_rx_sop ? 15'd0 : {1'b0, len}) + {1'b0, bytes};
  assign len_nx = sum[14] ? 14'h3fff : sum[13:0];
  assign err_nx = pkt_rx_err || (!pkt_rx_sop && err_acc);
  assign bad_nx = err_nx || len_nx < 14'(MIN_LEN) || len_nx > 14'(MAX_LEN);
  assign discard = pkt_rx_val && !pkt_rx_sop && !in_frame;
  assign trunc = pkt_rx_val && pkt_rx_sop && in_frame;
  assign close = pkt_rx_val && pkt_rx_eop && !discard;
  assign push = pkt_rx_val && !discard;
  assign pop = out_valid && out_ready;
  assign we = push && (count != (AW+1)'(FIFO_DEPTH) || pop);
  assign out_valid = count != '0;
  assign head = out_valid ? mem[rd_ptr] : '0;
  assign {out_data, out_sop, out_eop, out_err, out_mod} = head;
  assign err_sum = {1'b0, err_count} + 17'(frame_done & frame_bad) + 17'(discard);
  always_ff @(posedge clk_156m25)
    if (we) mem[wr_ptr] <= {pkt_rx_data, pkt_rx_sop, pkt_rx_eop, pkt_rx_err || (pkt_rx_eop && bad_nx), pkt_rx_mod};
  always_ff @(posedge clk_156m25 or posedge reset_156m25)
    if (reset_156m25) begin
      state <= IDLE;
      ren_q <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      in_frame <= 1'b0;
      err_acc <= 1'b0;
      len <= '0;
      pend_v <= 1'b0;
      pend_len <= '0;
      pend_bad <= 1'b0;
      frame_done <= 1'b0;
      frame_len <= '0;
      frame_bad <= 1'b0;
      frame_count <= '0;
      err_count <= '0;
    end else begin
      state <= state_nx;
      ren_q <= pkt_rx_ren;
      wr_ptr <= we ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count <= count + (AW+1)'(we) - (AW+1)'(pop);
      if (push) begin
        in_frame <= !pkt_rx_eop;
        len <= len_nx;
        err_acc <= err_nx;
      end
      // a truncating sop+eop word defers its own pulse one cycle behind the truncation pulse
      frame_done <= trunc || close || pend_v;
      frame_len <= trunc ? len : close ? len_nx : pend_v ? pend_len : 14'd0;
      frame_bad <= trunc || (close ? bad_nx : pend_v && pend_bad);
      pend_v <= trunc && close;
      pend_len <= len_nx;
      pend_bad <= bad_nx;
      frame_count <= frame_count + 32'(frame_done);
      err_count <= err_sum[16] ? 16'hffff : err_sum[15:0];
    end
endmodule

// File: tb/tb_pkt_rx_reader.sv
// tb_pkt_rx_reader: directed bench with a MAC responder and an output scoreboard.
module tb_pkt_rx_reader;
  localparam int D = 8;
  typedef logic [69:0] word_t;
  logic clk_156m25 = 1'b0, reset_156m25 = 1'b1;
  logic pkt_rx_avail = 1'b0, pkt_rx_ren, pkt_rx_val = 1'b0;
  logic [63:0] pkt_rx_data = '0;
  logic pkt_rx_sop = 1'b0, pkt_rx_eop = 1'b0, pkt_rx_err = 1'b0;
  logic [2:0] pkt_rx_mod = '0;
  logic [63:0] out_data;
  logic out_sop, out_eop, out_err, out_valid, out_ready = 1'b0;
  logic [2:0] out_mod;
  logic frame_done, frame_bad;
  logic [13:0] frame_len;
  logic [31:0] frame_count;
  logic [15:0] err_count;
  word_t mac_q[$], exp_q[$];
  int done_len[$], done_bad[$], done_cyc[$];
  int checks = 0, passed = 0, cyc = 0, occ = 0, max_occ = 0, got = 0, bad_words = 0, sync_err = 0, sent = 0, rdy_mode = 1;
  logic ren_q = 1'b0, last_ren = 1'b0, tog = 1'b0, last_eop_err = 1'b0;

  pkt_rx_reader #(.FIFO_DEPTH(D), .MIN_LEN(64), .MAX_LEN(1518)) dut (
    .clk_156m25(clk_156m25), .reset_156m25(reset_156m25),
    .pkt_rx_avail(pkt_rx_avail), .pkt_rx_ren(pkt_rx_ren), .pkt_rx_val(pkt_rx_val),
    .pkt_rx_data(pkt_rx_data), .pkt_rx_sop(pkt_rx_sop), .pkt_rx_eop(pkt_rx_eop),
    .pkt_rx_err(pkt_rx_err), .pkt_rx_mod(pkt_rx_mod),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .out_err(out_err),
    .out_mod(out_mod), .out_valid(out_valid), .out_ready(out_ready),
    .frame_done(frame_done), .frame_len(frame_len), .frame_bad(frame_bad),
    .frame_count(frame_count), .err_count(err_count)
  );

  always #5 clk_156m25 = ~clk_156m25;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clear();
    got = 0; bad_words = 0; sent = 0; max_occ = occ;
    done_len.delete(); done_bad.delete(); done_cyc.delete();
  endtask

  // cut=1 builds a frame with no eop word (it will be truncated by the next sop)
  task automatic add_frame(input int nw, input int lm, input int tag, input bit cut);
    int len;
    bit bad, e;
    word_t w;
    len = (nw - 1) * 8 + (lm == 0 ? 8 : lm);
    bad = len < 64 || len > 1518;
    for (int i = 0; i < nw; i++) begin
      e = (i == nw - 1) && !cut;
      w = {32'(tag), 32'(i), 1'(i == 0), 1'(e), 1'b0, e ? 3'(lm) : 3'd0};
      mac_q.push_back(w);
      w[3] = e && bad;
      exp_q.push_back(w);
    end
  endtask

  task automatic tick();
    word_t w, h;
    @(negedge clk_156m25);
    cyc++;
    tog = !tog;
    out_ready = (rdy_mode == 2) ? tog : (rdy_mode == 1);
    if (ren_q && mac_q.size() > 0) begin
      w = mac_q.pop_front();
      {pkt_rx_data, pkt_rx_sop, pkt_rx_eop, pkt_rx_err, pkt_rx_mod} = w;
      pkt_rx_val = 1'b1;
      sent++;
    end else begin
      pkt_rx_val = 1'b0; pkt_rx_sop = 1'b0; pkt_rx_eop = 1'b0; pkt_rx_err = 1'b0; pkt_rx_mod = '0;
    end
    pkt_rx_avail = mac_q.size() > 0;
    #1;
    ren_q = pkt_rx_ren;
    last_ren = pkt_rx_ren;
    if (out_valid !== (occ != 0) || occ > D) sync_err++;
    if (out_valid && out_ready) begin
      h = {out_data, out_sop, out_eop, out_err, out_mod};
      if (exp_q.size() == 0 || h !== exp_q[0]) bad_words++;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (out_eop) last_eop_err = out_err;
      got++;
    end
    if (frame_done) begin
      done_len.push_back(int'(frame_len));
      done_bad.push_back(int'(frame_bad));
      done_cyc.push_back(cyc);
    end
    occ = occ + int'(pkt_rx_val) - int'(out_valid && out_ready);
    if (occ > max_occ) max_occ = occ;
  endtask

  task automatic run(input int nf, input int budget, input string tag);
    int n = 0;
    while ((done_len.size() < nf || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    repeat (2) tick();
    chk({tag, "_completes"}, 64'(n < budget), 64'd1);
    chk({tag, "_pulses"}, 64'(done_len.size()), 64'(nf));
  endtask

  initial begin
    repeat (3) @(negedge clk_156m25);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_ren", 64'(pkt_rx_ren), 0);
    chk("rst_frame_count", 64'(frame_count), 0);
    chk("rst_err_count", 64'(err_count), 0);
    reset_156m25 = 1'b0;

    clear(); rdy_mode = 1;
    add_frame(8, 0, 1, 0);
    run(1, 200, "s1");
    chk("s1_words", 64'(got), 8);
    chk("s1_order", 64'(bad_words), 0);
    chk("s1_len", 64'(done_len[0]), 64);
    chk("s1_bad", 64'(done_bad[0]), 0);
    chk("s1_frame_count", 64'(frame_count), 1);

    clear();
    add_frame(8, 5, 2, 0);
    run(1, 200, "s2");
    chk("s2_len", 64'(done_len[0]), 61);
    chk("s2_bad", 64'(done_bad[0]), 1);
    chk("s2_out_err", 64'(last_eop_err), 1);
    chk("s2_order", 64'(bad_words), 0);
    chk("s2_err_count", 64'(err_count), 1);

    clear(); rdy_mode = 0;
    add_frame(190, 6, 3, 0);
    repeat (60) tick();
    chk("s3_max_occ", 64'(max_occ), D - 1);
    chk("s3_ren_stopped", 64'(last_ren), 0);
    chk("s3_no_pop", 64'(got), 0);
    rdy_mode = 2;
    run(1, 3000, "s4");
    chk("s4_words", 64'(got), 190);
    chk("s4_order", 64'(bad_words), 0);
    chk("s4_len", 64'(done_len[0]), 1518);
    chk("s4_bad", 64'(done_bad[0]), 0);
    chk("s4_occ_track", 64'(sync_err), 0);

    clear(); rdy_mode = 1;
    add_frame(3, 0, 4, 1);
    add_frame(8, 0, 5, 0);
    run(2, 300, "s5");
    chk("s5_len0", 64'(done_len[0]), 24);
    chk("s5_bad0", 64'(done_bad[0]), 1);
    chk("s5_len1", 64'(done_len[1]), 64);
    chk("s5_bad1", 64'(done_bad[1]), 0);
    chk("s5_order", 64'(bad_words), 0);
    chk("s5_frame_count", 64'(frame_count), 5);

    clear();
    add_frame(2, 0, 6, 1);
    add_frame(1, 0, 7, 0);
    run(2, 200, "s5b");
    chk("s5b_len0", 64'(done_len[0]), 16);
    chk("s5b_len1", 64'(done_len[1]), 8);
    chk("s5b_bad1", 64'(done_bad[1]), 1);
    chk("s5b_gap", 64'(done_cyc[1] - done_cyc[0]), 1);
    chk("s5b_order", 64'(bad_words), 0);
    chk("s5b_err_count", 64'(err_count), 4);
    chk("s5b_frame_count", 64'(frame_count), 7);

    clear();
    @(negedge clk_156m25);
    pkt_rx_val = 1'b1; pkt_rx_sop = 1'b0; pkt_rx_eop = 1'b0; pkt_rx_data = 64'hdead;
    @(negedge clk_156m25);
    pkt_rx_val = 1'b0;
    repeat (3) tick();
    chk("s6_no_push", 64'(out_valid), 0);
    chk("s6_err_count", 64'(err_count), 5);
    chk("s6_no_pulse", 64'(done_len.size()), 0);
    chk("s6_frame_count", 64'(frame_count), 7);

    clear(); rdy_mode = 0;
    add_frame(8, 0, 8, 0);
    for (int n = 0; n < 50 && sent < 5; n++) tick();
    chk("s7_reached_word4", 64'(sent), 5);
    chk("s7_pre_valid", 64'(out_valid), 1);
    #1 reset_156m25 = 1'b1;
    pkt_rx_val = 1'b0; pkt_rx_avail = 1'b0;
    #1;
    chk("s7_rst_valid", 64'(out_valid), 0);
    chk("s7_rst_data", out_data, 0);
    chk("s7_rst_ren", 64'(pkt_rx_ren), 0);
    chk("s7_rst_frame_count", 64'(frame_count), 0);
    chk("s7_rst_err_count", 64'(err_count), 0);
    mac_q.delete(); exp_q.delete();
    occ = 0; ren_q = 1'b0;
    repeat (2) @(negedge clk_156m25);
    reset_156m25 = 1'b0;
    clear(); rdy_mode = 1;
    add_frame(8, 0, 9, 0);
    run(1, 200, "s7");
    chk("s7_len", 64'(done_len[0]), 64);
    chk("s7_bad", 64'(done_bad[0]), 0);
    chk("s7_words", 64'(got), 8);
    chk("s7_order", 64'(bad_words), 0);
    chk("s7_frame_count", 64'(frame_count), 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
